result_stream_reader: RTL and testbench

Drains a block of result rows from the datapath's result BRAM (R) and presents them to the PS side as a valid/ready stream, one PE_COUNT-wide row per beat. It sits between the datapath read port (bram_r_r_addr / bram_r_r_data) and the PS interconnect. It is the read-side counterpart of the PS-driven A/B/INS write ports. It hides the fixed BRAM read latency and absorbs downstream backpressure without losing or duplicating rows.

---
 rtl/result_stream_reader.sv | 203 ++++++++++++++++++++
 tb/tb_result_stream_reader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_stream_reader.sv
// result_stream_reader
// Reads a block of rows from the result BRAM and presents them as a
// valid/ready stream, one row per beat. A small output FIFO hides the fixed
// BRAM read latency. A credit check on reads stops the FIFO from overflowing
// when the downstream side stalls.
module result_stream_reader #(
  parameter int PE_COUNT       = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int INS_ADDR_WIDTH = 11,
  parameter int RD_LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [INS_ADDR_WIDTH-1:0]      start_addr,
  input  logic [INS_ADDR_WIDTH:0]        num_rows,
  output logic [INS_ADDR_WIDTH-1:0]      bram_r_r_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_r_data,
  output logic [PE_COUNT*DATA_WIDTH-1:0] m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic                           busy,
  output logic                           done
);

  localparam int ROW_W      = PE_COUNT * DATA_WIDTH;
  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int LEN_W      = INS_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t                    state_reg, state_next;
  logic [INS_ADDR_WIDTH-1:0] addr_reg;
  logic [LEN_W-1:0]          num_rows_reg;
  logic [LEN_W-1:0]          issued_cnt_reg;
  logic [LEN_W-1:0]          beat_cnt_reg;
  logic                      done_reg, done_next;
  logic                      rd_issue_reg;
  logic [RD_LATENCY-1:0]     rd_pipe_reg;

  logic [ROW_W-1:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]          fifo_count_reg;

  logic                      start_issue, run_issue;
  logic                      push, pop;
  logic [CNT_W-1:0]          inflight;
  logic [CNT_W-1:0]          occupancy;
  logic                      credit_ok;

  // Row arrives from the BRAM when the in-flight pipe tap fires; it leaves on a handshake.
  assign push    = rd_pipe_reg[RD_LATENCY-1];
  assign m_valid = (fifo_count_reg != '0);
  assign pop     = m_valid & m_ready;

  assign bram_r_r_addr = addr_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign done          = done_reg;
  assign m_data        = m_valid ? fifo_mem[rd_ptr_reg] : '0;
  assign m_last        = m_valid && ((beat_cnt_reg + LEN_W'(1)) == num_rows_reg);

  // Count reads issued but not yet written into the FIFO (address stage plus pipe).
  always_comb begin
    inflight = CNT_W'(rd_issue_reg);
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(rd_pipe_reg[i]);
    end
  end

  // A row popped this cycle frees its slot in time for a read issued now.
  assign occupancy = fifo_count_reg + inflight;
  assign credit_ok = (occupancy - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, read-issue and done decisions.
  always_comb begin
    state_next  = state_reg;
    start_issue = 1'b0;
    run_issue   = 1'b0;
    done_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (num_rows == '0) begin
            done_next = 1'b1;
          end else begin
            start_issue = 1'b1;
            state_next  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (issued_cnt_reg == num_rows_reg) begin
          state_next = ST_FLUSH;
        end else if (credit_ok) begin
          run_issue = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (pop && m_last) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Transfer bookkeeping: read address, issue/beat counters and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg       <= '0;
      num_rows_reg   <= '0;
      issued_cnt_reg <= '0;
      beat_cnt_reg   <= '0;
      done_reg       <= 1'b0;
      rd_issue_reg   <= 1'b0;
    end else begin
      done_reg     <= done_next;
      rd_issue_reg <= start_issue | run_issue;
      if (start_issue) begin
        addr_reg       <= start_addr;
        num_rows_reg   <= num_rows;
        issued_cnt_reg <= LEN_W'(1);
      end else if (run_issue) begin
        addr_reg       <= addr_reg + INS_ADDR_WIDTH'(1);
        issued_cnt_reg <= issued_cnt_reg + LEN_W'(1);
      end
      if (start_issue) begin
        beat_cnt_reg <= '0;
      end else if (pop) begin
        beat_cnt_reg <= beat_cnt_reg + LEN_W'(1);
      end
    end
  end

  // First in-flight stage follows the address-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe_reg[0] <= 1'b0;
    end else begin
      rd_pipe_reg[0] <= rd_issue_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < RD_LATENCY; gi++) begin : g_pipe
      // Remaining in-flight stages shift toward the FIFO write tap.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_pipe_reg[gi] <= 1'b0;
        end else begin
          rd_pipe_reg[gi] <= rd_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  // FIFO storage is a small register file so the head row is visible with no extra latency.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= bram_r_r_data;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_result_stream_reader.sv
// Testbench for result_stream_reader: a BRAM model with two cycles of read
// latency, a randomized/pattern m_ready driver, and an expected-row model
// computed from the row contents formula (row a, lane j = 4a+j).
module tb_result_stream_reader;

  localparam int AW    = 11;
  localparam int NROWS = 2048;
  typedef logic [127:0] row_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   num_rows;
  logic [AW-1:0] bram_r_r_addr;
  row_t          bram_r_r_data;
  row_t          m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          done;

  int total;
  int bad;

  result_stream_reader #(
    .PE_COUNT(4), .DATA_WIDTH(32), .INS_ADDR_WIDTH(AW), .RD_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .num_rows(num_rows), .bram_r_r_addr(bram_r_r_addr),
    .bram_r_r_data(bram_r_r_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected content of result row a.
  function automatic row_t exp_row(input int a);
    row_t r;
    for (int j = 0; j < 4; j++) r[j*32 +: 32] = 32'(4 * a + j);
    return r;
  endfunction

  // Result BRAM model, read latency 2.
  row_t mem [NROWS];
  row_t rd_d1;
  initial begin
    for (int i = 0; i < NROWS; i++) mem[i] = exp_row(i);
  end
  always @(posedge clk) begin
    rd_d1         <= mem[bram_r_r_addr];
    bram_r_r_data <= rd_d1;
  end

  // Observations gathered by run_xfer.
  row_t got_rows[$];
  int   got_cyc[$];
  int   got_last[$];
  int   got_addr[$];
  int   first_valid, done_cyc, stall_chg, stall_addr_cnt;
  bit   busy1, busy_done, timeout;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer starting in the current cycle (relative cycle 0) and
  // returns in the cycle done is observed high. mode: 0 ready=1,
  // 1 toggle 1,0,..., 2 ready=0 for stall_len cycles, 3 random.
  task automatic run_xfer(input int s_addr, input int n, input int mode,
                          input int stall_len, input int inject_at,
                          input int inject_addr);
    int   rel;
    bit   prev_stall;
    row_t prev_data;
    got_rows.delete(); got_cyc.delete(); got_last.delete(); got_addr.delete();
    first_valid = -1; done_cyc = -1; stall_chg = 0; stall_addr_cnt = -1;
    busy1 = 1'b0; busy_done = 1'b1; timeout = 1'b0; prev_stall = 1'b0;
    prev_data = '0;
    rel = 0;
    forever begin
      if (rel == 0) begin
        start = 1'b1; start_addr = AW'(s_addr); num_rows = (AW+1)'(n);
      end else if (rel == inject_at) begin
        start = 1'b1; start_addr = AW'(inject_addr); num_rows = (AW+1)'(n);
      end else begin
        start = 1'b0;
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (rel % 2 == 0);
        2:       m_ready = (rel >= stall_len);
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (rel > 0) begin
        if (rel == 1) busy1 = busy;
        if (m_valid && first_valid < 0) first_valid = rel;
        if (busy && (got_addr.size() == 0 || got_addr[$] != int'(bram_r_r_addr)))
          got_addr.push_back(int'(bram_r_r_addr));
        if (mode == 2 && rel == stall_len) stall_addr_cnt = got_addr.size();
        if (prev_stall && (!m_valid || m_data !== prev_data)) stall_chg++;
        if (m_valid && m_ready) begin
          if (m_last) got_last.push_back(got_rows.size());
          got_rows.push_back(m_data);
          got_cyc.push_back(rel);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (done) begin
          done_cyc  = rel;
          busy_done = busy;
          break;
        end
      end
      if (rel > 3000) begin
        timeout = 1'b1;
        start = 1'b0;
        break;
      end
      tick;
      rel++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start_addr = '0; num_rows = '0; m_ready = 1'b0;
    tick; tick;
    total++; if (bram_r_r_addr !== '0) begin bad++; $display("FAIL reset_addr: got %0d want 0", bram_r_r_addr); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", m_last); end
    total++; if (m_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", m_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    tick;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_basic;
    run_xfer(0, 4, 0, 0, -1, 0);
    total++; if (timeout) begin bad++; $display("FAIL basic_timeout: got timeout want done"); end
    total++; if (first_valid != 4) begin bad++; $display("FAIL basic_first_valid: got T+%0d want T+4", first_valid); end
    total++; if (done_cyc != 8) begin bad++; $display("FAIL basic_done: got T+%0d want T+8", done_cyc); end
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL basic_busy_t1: got %b want 1", busy1); end
    total++; if (busy_done !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy_done); end
    total++; if (got_rows.size() != 4) begin bad++; $display("FAIL basic_count: got %0d want 4", got_rows.size()); end
    for (int k = 0; k < got_rows.size() && k < 4; k++) begin
      total++; if (got_rows[k] !== exp_row(k)) begin bad++; $display("FAIL basic_row%0d: got %h want %h", k, got_rows[k], exp_row(k)); end
      total++; if (got_cyc[k] != 4 + k) begin bad++; $display("FAIL basic_cyc%0d: got T+%0d want T+%0d", k, got_cyc[k], 4 + k); end
    end
    total++; if (got_last.size() != 1 || got_last[0] != 3) begin bad++; $display("FAIL basic_last: got %0d lasts want one on beat 3", got_last.size()); end
    $display("basic: %0d beats, done at T+%0d", got_rows.size(), done_cyc);
  endtask

  task automatic test_backpressure;
    run_xfer(10, 16, 1, 0, -1, 0);
    total++; if (timeout) begin bad++; $display("FAIL bp_timeout: got timeout want done"); end
    total++; if (got_rows.size() != 16) begin bad++; $display("FAIL bp_count: got %0d want 16", got_rows.size()); end
    for (int k = 0; k < got_rows.size() && k < 16; k++) begin
      total++; if (got_rows[k] !== exp_row(10 + k)) begin bad++; $display("FAIL bp_row%0d: got %h want %h", k, got_rows[k], exp_row(10 + k)); end
    end
    total++; if (stall_chg != 0) begin bad++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stall_chg); end
    total++; if (got_last.size() != 1 || got_last[0] != 15) begin bad++; $display("FAIL bp_last: got %0d lasts want one on beat 15", got_last.size()); end
    $display("backpressure: %0d beats, done at T+%0d", got_rows.size(), done_cyc);
  endtask

  task automatic test_stall_full;
    run_xfer(500, 32, 2, 20, -1, 0);
    total++; if (timeout) begin bad++; $display("FAIL stall_timeout: got timeout want done"); end
    total++; if (stall_addr_cnt != 4) begin bad++; $display("FAIL stall_addr_count: got %0d reads want 4", stall_addr_cnt); end
    total++; if (got_rows.size() != 32) begin bad++; $display("FAIL stall_count: got %0d want 32", got_rows.size()); end
    for (int k = 0; k < got_rows.size() && k < 32; k++) begin
      total++; if (got_rows[k] !== exp_row(500 + k)) begin bad++; $display("FAIL stall_row%0d: got %h want %h", k, got_rows[k], exp_row(500 + k)); end
      total++; if (got_cyc[k] != 20 + k) begin bad++; $display("FAIL stall_cyc%0d: got T+%0d want T+%0d", k, got_cyc[k], 20 + k); end
    end
    total++; if (stall_chg != 0) begin bad++; $display("FAIL stall_stable: got %0d changes want 0", stall_chg); end
    $display("stall: %0d reads before release, %0d beats", stall_addr_cnt, got_rows.size());
  endtask

  task automatic test_wrap;
    int exp_a;
    run_xfer(2046, 4, 0, 0, -1, 0);
    total++; if (timeout) begin bad++; $display("FAIL wrap_timeout: got timeout want done"); end
    total++; if (got_addr.size() != 4) begin bad++; $display("FAIL wrap_addr_count: got %0d want 4", got_addr.size()); end
    total++; if (got_rows.size() != 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", got_rows.size()); end
    for (int k = 0; k < 4; k++) begin
      exp_a = (2046 + k) % NROWS;
      if (k < got_addr.size()) begin
        total++; if (got_addr[k] != exp_a) begin bad++; $display("FAIL wrap_addr%0d: got %0d want %0d", k, got_addr[k], exp_a); end
      end
      if (k < got_rows.size()) begin
        total++; if (got_rows[k] !== exp_row(exp_a)) begin bad++; $display("FAIL wrap_row%0d: got %h want %h", k, got_rows[k], exp_row(exp_a)); end
      end
    end
    $display("wrap: addresses %0d..%0d", (got_addr.size() > 0) ? got_addr[0] : -1, (got_addr.size() > 0) ? got_addr[$] : -1);
  endtask

  task automatic test_zero_and_ignored_start;
    run_xfer(77, 0, 0, 0, -1, 0);
    total++; if (done_cyc != 1) begin bad++; $display("FAIL zero_done: got T+%0d want T+1", done_cyc); end
    total++; if (first_valid != -1) begin bad++; $display("FAIL zero_valid: got valid at T+%0d want never", first_valid); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy1); end
    $display("zero: done at T+%0d", done_cyc);
    run_xfer(300, 8, 0, 0, 5, 700);
    total++; if (timeout) begin bad++; $display("FAIL ignore_timeout: got timeout want done"); end
    total++; if (got_rows.size() != 8) begin bad++; $display("FAIL ignore_count: got %0d want 8", got_rows.size()); end
    for (int k = 0; k < got_rows.size() && k < 8; k++) begin
      total++; if (got_rows[k] !== exp_row(300 + k)) begin bad++; $display("FAIL ignore_row%0d: got %h want %h", k, got_rows[k], exp_row(300 + k)); end
    end
    total++; if (done_cyc != 12) begin bad++; $display("FAIL ignore_done: got T+%0d want T+12", done_cyc); end
    tick; tick; tick;
    total++; if (busy !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL ignore_idle_after: got busy=%b valid=%b want 0/0", busy, m_valid); end
    $display("ignored start: %0d beats, done at T+%0d", got_rows.size(), done_cyc);
  endtask

  task automatic test_back_to_back;
    run_xfer(40, 3, 0, 0, -1, 0);
    total++; if (done_cyc != 7) begin bad++; $display("FAIL b2b_first_done: got T+%0d want T+7", done_cyc); end
    run_xfer(900, 5, 0, 0, -1, 0);
    total++; if (first_valid != 4) begin bad++; $display("FAIL b2b_first_valid: got T+%0d want T+4", first_valid); end
    total++; if (done_cyc != 9) begin bad++; $display("FAIL b2b_done: got T+%0d want T+9", done_cyc); end
    total++; if (got_rows.size() != 5) begin bad++; $display("FAIL b2b_count: got %0d want 5", got_rows.size()); end
    for (int k = 0; k < got_rows.size() && k < 5; k++) begin
      total++; if (got_rows[k] !== exp_row(900 + k)) begin bad++; $display("FAIL b2b_row%0d: got %h want %h", k, got_rows[k], exp_row(900 + k)); end
    end
    $display("back_to_back: second done at T+%0d", done_cyc);
  endtask

  task automatic test_reset_midstream;
    int hs, rel, done_seen, valid_seen;
    start = 1'b1; start_addr = '0; num_rows = (AW+1)'(8); m_ready = 1'b1;
    tick;
    start = 1'b0;
    hs = 0; rel = 1;
    while (hs < 2 && rel < 40) begin
      if (m_valid && m_ready) hs++;
      tick;
      rel++;
    end
    total++; if (hs != 2) begin bad++; $display("FAIL rstmid_beats: got %0d beats want 2", hs); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", m_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", done); end
    done_seen = 0; valid_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) done_seen++;
      if (m_valid) valid_seen++;
      tick;
    end
    total++; if (done_seen != 0 || valid_seen != 0) begin bad++; $display("FAIL rstmid_quiet: got done=%0d valid=%0d want 0/0", done_seen, valid_seen); end
    run_xfer(100, 2, 0, 0, -1, 0);
    total++; if (got_rows.size() != 2) begin bad++; $display("FAIL rstmid_count: got %0d want 2", got_rows.size()); end
    for (int k = 0; k < got_rows.size() && k < 2; k++) begin
      total++; if (got_rows[k] !== exp_row(100 + k)) begin bad++; $display("FAIL rstmid_row%0d: got %h want %h", k, got_rows[k], exp_row(100 + k)); end
    end
    $display("reset midstream: restart gave %0d beats", got_rows.size());
  endtask

  task automatic test_random;
    int a, n, exp_a;
    for (int it = 0; it < 6; it++) begin
      a = $urandom_range(0, NROWS - 1);
      n = $urandom_range(1, 40);
      run_xfer(a, n, 3, 0, -1, 0);
      total++; if (timeout) begin bad++; $display("FAIL rand%0d_timeout: got timeout want done", it); end
      total++; if (got_rows.size() != n) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", it, got_rows.size(), n); end
      for (int k = 0; k < got_rows.size() && k < n; k++) begin
        exp_a = (a + k) % NROWS;
        total++; if (got_rows[k] !== exp_row(exp_a)) begin bad++; $display("FAIL rand%0d_row%0d: got %h want %h", it, k, got_rows[k], exp_row(exp_a)); end
      end
      total++; if (got_last.size() != 1 || got_last[0] != n - 1) begin bad++; $display("FAIL rand%0d_last: got %0d lasts want one on beat %0d", it, got_last.size(), n - 1); end
      total++; if (stall_chg != 0) begin bad++; $display("FAIL rand%0d_stable: got %0d changes want 0", it, stall_chg); end
      $display("random %0d: addr=%0d rows=%0d beats=%0d done at T+%0d", it, a, n, got_rows.size(), done_cyc);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_basic;
    test_backpressure;
    test_stall_full;
    test_wrap;
    test_zero_and_ignored_start;
    test_back_to_back;
    test_reset_midstream;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
